// File: rtl/csa_pkg.sv
// Shared constants and full-adder cell helpers for the 16-bit carry-select adder.
package csa_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned BLOCK_W    = 4;
    localparam int unsigned NUM_BLOCKS = WIDTH / BLOCK_W;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (ci & (x ^ y));
    endfunction

endpackage

// File: rtl/csa_block4.sv
// One carry-select block: two ripple chains (carry-in 0 and 1) plus output muxes.
// In ripple mode the carry-in-0 chain is fed by ci directly and always selected.
module csa_block4
    import csa_pkg::*;
(
    input  logic               ripple_mode,
    input  logic               ci,
    input  logic [BLOCK_W-1:0] x,
    input  logic [BLOCK_W-1:0] y,
    output logic               co,
    output logic [BLOCK_W-1:0] sum
);

    logic [BLOCK_W:0]   carry0_s;
    logic [BLOCK_W:0]   carry1_s;
    logic [BLOCK_W-1:0] sum0_s;
    logic [BLOCK_W-1:0] sum1_s;
    logic               sel_s;

    // Chain with carry-in 0, doubling as the single ripple chain in ripple mode
    always_comb begin
        carry0_s = '0;
        sum0_s   = '0;
        if (ripple_mode) begin
            carry0_s[0] = ci;
        end else begin
            carry0_s[0] = 1'b0;
        end
        for (int i = 0; i < BLOCK_W; i++) begin
            sum0_s[i]     = fa_sum(x[i], y[i], carry0_s[i]);
            carry0_s[i+1] = fa_carry(x[i], y[i], carry0_s[i]);
        end
    end

    // Chain with carry-in fixed to 1
    always_comb begin
        carry1_s    = '0;
        sum1_s      = '0;
        carry1_s[0] = 1'b1;
        for (int i = 0; i < BLOCK_W; i++) begin
            sum1_s[i]     = fa_sum(x[i], y[i], carry1_s[i]);
            carry1_s[i+1] = fa_carry(x[i], y[i], carry1_s[i]);
        end
    end

    // Incoming carry picks a chain; select 1 means the carry-in-1 chain
    always_comb begin
        sel_s = 1'b0;
        sum   = '0;
        co    = 1'b0;
        if (ripple_mode) begin
            sel_s = 1'b0;
        end else begin
            sel_s = ci;
        end
        if (sel_s) begin
            sum = sum1_s;
            co  = carry1_s[BLOCK_W];
        end else begin
            sum = sum0_s;
            co  = carry0_s[BLOCK_W];
        end
    end

endmodule

// File: rtl/carry_select_adder_16_reg.sv
// Registered 16-bit carry-select adder: {c_out, s} = a + b + c_in, one cycle latency.
module carry_select_adder_16_reg
    import csa_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             c_out,
    output logic [WIDTH-1:0] s
);

    logic [WIDTH-1:0] sum_s;
    logic             carry_top_s;
    logic [WIDTH-1:0] s_r;
    logic             c_out_r;
    logic             out_valid_r;

    // Per-block carry wires kept separate so the chain is not one self-referencing vector
    for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_blk
        logic ci_s;
        logic co_s;

        if (g == 0) begin : g_first
            assign ci_s = c_in;
        end else begin : g_next
            assign ci_s = g_blk[g-1].co_s;
        end

        csa_block4 u_block (
            .ripple_mode ((g == 0) ? 1'b1 : 1'b0),
            .ci          (ci_s),
            .x           (a[g*BLOCK_W +: BLOCK_W]),
            .y           (b[g*BLOCK_W +: BLOCK_W]),
            .co          (co_s),
            .sum         (sum_s[g*BLOCK_W +: BLOCK_W])
        );
    end

    assign carry_top_s = g_blk[NUM_BLOCKS-1].co_s;

    // Result captured every cycle; out_valid qualifies it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r         <= '0;
            c_out_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            s_r         <= sum_s;
            c_out_r     <= carry_top_s;
            out_valid_r <= in_valid;
        end
    end

    assign s         = s_r;
    assign c_out     = c_out_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_carry_select_adder_16_reg.sv
// Self-checking bench: arithmetic reference model, directed literal vectors, block sweep.
module tb_carry_select_adder_16_reg;
    import csa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        c_in;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        c_out;
    logic [15:0] s;

    // reference model state
    logic        exp_valid;
    logic [16:0] exp_res;
    logic [1:0]  pend_kind = 2'd0;
    string       pend_name = "";
    logic [17:0] pend_val = 18'd0;
    logic [1:0]  lit_kind;
    string       lit_name;
    logic [17:0] lit_val;

    // block sweep signals
    logic [3:0]  bx = 4'd0;
    logic [3:0]  by = 4'd0;
    logic        bci = 1'b0;
    logic [3:0]  bsum_sel;
    logic [3:0]  bsum_rip;
    logic        bco_sel;
    logic        bco_rip;
    logic [4:0]  e5;
    logic        sweep_go = 1'b0;
    logic        sweep_done = 1'b0;

    int total = 0;
    int bad = 0;

    carry_select_adder_16_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .c_in      (c_in),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .c_out     (c_out),
        .s         (s)
    );

    csa_block4 u_blk_sel (
        .ripple_mode (1'b0),
        .ci          (bci),
        .x           (bx),
        .y           (by),
        .co          (bco_sel),
        .sum         (bsum_sel)
    );

    csa_block4 u_blk_rip (
        .ripple_mode (1'b1),
        .ci          (bci),
        .x           (bx),
        .y           (by),
        .co          (bco_rip),
        .sum         (bsum_rip)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Reference model: registered a + b + c_in, plus pipelined literal expectations
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid <= 1'b0;
            exp_res   <= 17'd0;
            lit_kind  <= 2'd0;
            lit_name  <= "";
            lit_val   <= 18'd0;
        end else begin
            exp_valid <= in_valid;
            exp_res   <= {1'b0, a} + {1'b0, b} + {16'd0, c_in};
            lit_kind  <= pend_kind;
            lit_name  <= pend_name;
            lit_val   <= pend_val;
        end
    end

    // Single compare process
    always @(negedge clk or negedge rst_n or posedge sweep_go) begin
        if (sweep_go && !sweep_done) begin
            for (int i = 0; i < 512; i++) begin
                {bci, bx, by} = 9'(i);
                #1;
                e5 = {1'b0, bx} + {1'b0, by} + {4'd0, bci};
                check("blk_select", {13'd0, bco_sel, bsum_sel}, {13'd0, e5});
                check("blk_ripple", {13'd0, bco_rip, bsum_rip}, {13'd0, e5});
            end
            sweep_done = 1'b1;
        end else if (!rst_n) begin
            #1;
            check("rst_clear", {out_valid, c_out, s}, 18'd0);
        end else begin
            check("out_valid", {17'd0, out_valid}, {17'd0, exp_valid});
            if (exp_valid) begin
                check("result", {1'b0, c_out, s}, {1'b0, exp_res});
            end
            if (lit_kind == 2'd1) begin
                check(lit_name, {out_valid, c_out, s}, lit_val);
            end else if (lit_kind == 2'd2) begin
                check(lit_name, {17'd0, out_valid}, {17'd0, lit_val[17]});
            end
        end
    end

    task automatic step(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic tv, input logic [1:0] k, input string nm,
                        input logic [17:0] v);
        @(posedge clk);
        #2;
        a         = ta;
        b         = tb_v;
        c_in      = tc;
        in_valid  = tv;
        pend_kind = k;
        pend_name = nm;
        pend_val  = v;
    endtask

    initial begin
        a        = 16'($urandom);
        b        = 16'($urandom);
        c_in     = 1'($urandom);
        in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #2;
            a        = 16'($urandom);
            b        = 16'($urandom);
            c_in     = 1'($urandom);
            in_valid = 1'($urandom);
        end
        rst_n = 1'b1;

        // {out_valid, c_out, s}
        step(16'h1234, 16'h4321, 1'b0, 1'b1, 2'd1, "first_add", 18'h25555);
        step(16'h000E, 16'h0001, 1'b0, 1'b1, 2'd1, "blk_e_1",   18'h2000F);
        step(16'h0003, 16'h0008, 1'b0, 1'b1, 2'd1, "blk_3_8",   18'h2000B);
        step(16'h000F, 16'h000F, 1'b0, 1'b1, 2'd1, "blk_f_f",   18'h2001E);
        step(16'hFFFF, 16'h0000, 1'b1, 1'b1, 2'd1, "prop_all",  18'h30000);
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 2'd1, "ones_ones", 18'h3FFFF);

        for (int i = 0; i < 6; i++) begin
            step(16'($urandom), 16'($urandom), (i >= 3) ? 1'b1 : 1'b0, 1'b1, 2'd0, "", 18'd0);
        end

        step(16'hxxxx, 16'hxxxx, 1'bx, 1'b0, 2'd2, "valid_gap",  18'h00000);
        step(16'h8000, 16'h8000, 1'b0, 1'b1, 2'd2, "valid_back", 18'h20000);
        step(16'h0000, 16'h0000, 1'b0, 1'b1, 2'd1, "zero_add",   18'h20000);
        step(16'($urandom), 16'($urandom), 1'b1, 1'b1, 2'd0, "", 18'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        step(16'h0001, 16'h0002, 1'b0, 1'b1, 2'd1, "post_pulse", 18'h20003);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 2'd0, "", 18'd0);
        repeat (3) @(posedge clk);

        sweep_go = 1'b1;
        repeat (80) @(posedge clk);
        if (!sweep_done) begin
            $display("FAIL sweep_timeout: got done=%0b expected done=1", sweep_done);
            $fatal(1, "block sweep did not complete");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
